cl2_pl_exu_regfile_mp: RTL and testbench
========================================

Name: cl2_pl_exu_regfile_mp

Overview:
Parametrised multi-port integer register file for the CL2 execute stage. It generalises the single-write, two-read regfile to NRD read ports and NWR write ports, with optional write-to-read bypass. It adds a per-register busy scoreboard so the issue stage can stall on pending long-latency writebacks (load, mul/div). Entry 0 is hard-wired to zero.

Parameters:
XLEN, 32, data width of each register
NUM, 32, number of architectural registers (16 for RV32E); power of two, >= 2
IDXW, $clog2(NUM), index width (derived, not overridden)
NRD, 2, number of read ports, 1..4
NWR, 2, number of write ports, 1..3
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
rd_idx_i  in  NRD*IDXW  read indices; port k uses bits [k*IDXW +: IDXW]
rd_dat_o  out  NRD*XLEN  read data, combinational; port k uses [k*XLEN +: XLEN]
rd_busy_o  out  NRD  scoreboard busy bit of the register addressed by each read port
wr_en_i  in  NWR  write enables
wr_idx_i  in  NWR*IDXW  write indices
wr_dat_i  in  NWR*XLEN  write data
sb_set_i  in  1  mark register sb_idx_i as pending (instruction issued with a long-latency rd)
sb_idx_i  in  IDXW  register to mark pending
busy_vec_o  out  NUM  full scoreboard vector, registered

Behaviour:
- Reset (async, rst_n_i low): all registers 1..NUM-1 = 0; all busy bits = 0. Outputs follow immediately: rd_dat_o = 0, rd_busy_o = 0, busy_vec_o = 0.
- Register 0: reads always return 0. Writes to index 0 are discarded. Busy bit 0 is constant 0, and sb_set_i to index 0 is ignored.
- Write: register i is updated on the rising edge when any wr_en_i[p] is high with wr_idx_i[p] == i.
- Write conflict: if several enabled ports address the same index, the highest port number wins. No error is flagged.
- Read, BYPASS = 0: rd_dat_o[k] = stored value of rd_idx_i[k]. Latency is 0 cycles (combinational); data written at edge N is visible after edge N.
- Read, BYPASS = 1: if any enabled write port targets rd_idx_i[k] (nonzero) in the same cycle, rd_dat_o[k] = that port's wr_dat_i. The highest port wins, matching the conflict rule. Otherwise the stored value is returned.
- Scoreboard, per register i != 0, updated on the rising edge:
  - set when sb_set_i && sb_idx_i == i;
  - cleared when any wr_en_i[p] && wr_idx_i[p] == i;
  - set and clear in the same cycle on the same index: set wins, because the new issue supersedes the older pending write;
  - otherwise the bit holds.
- rd_busy_o[k]:
  - BYPASS = 0: stored busy bit of rd_idx_i[k].
  - BYPASS = 1: 0 when a same-cycle write targets rd_idx_i[k], because the data is being forwarded; otherwise the stored bit. A same-cycle sb_set_i does not affect rd_busy_o until the next cycle.
- Writes to a non-busy register are legal (ordinary single-cycle ALU writeback) and leave busy at 0.
- Out-of-range indices (NUM not equal to 2^IDXW cannot occur) need no special handling.
- No internal state machine beyond the scoreboard bits; all storage uses the codebase flop cells with asynchronous reset.

Test Plan:
- Reset check: hold rst_n_i low, drive all rd_idx_i to 1..NRD -> rd_dat_o = 0, busy_vec_o = 0. Release reset, write x5 = 0xDEADBEEF via port 0 -> next cycle, reading x5 returns 0xDEADBEEF.
- x0 guard: write 0x12345678 to x0 on every port with sb_set_i at index 0 -> reading x0 returns 0 and busy_vec_o[0] = 0.
- Write conflict: port 0 writes x7 = 0x1111 and port 1 writes x7 = 0x2222 in the same cycle -> x7 reads 0x2222. With BYPASS = 1, the same-cycle read also returns 0x2222.
- Bypass timing:
  - BYPASS = 1: write x3 = 0xA5A5 while reading x3 -> same-cycle rd_dat_o = 0xA5A5.
  - BYPASS = 0: same stimulus -> old value that cycle, 0xA5A5 on the next cycle.
- Scoreboard lifecycle: sb_set_i on x10 -> busy_vec_o[10] = 1 on the next cycle and rd_busy_o = 1 for reads of x10. Port 1 writes x10 -> busy clears after the edge; with BYPASS = 1, rd_busy_o is 0 in the write cycle.
- Set and clear together: x10 is busy, then sb_set_i on x10 in the same cycle as a port 0 write to x10 -> data updated and busy_vec_o[10] stays 1. Assert rst_n_i mid-sequence -> busy and data return to 0 asynchronously.

Source files
------------

// File: rtl/cl2_pl_exu_regfile_mp.sv
// rtl/cl2_pl_exu_regfile_mp.sv - multi-port integer register file with busy scoreboard
// Entry 0 reads as zero; the highest-numbered write port wins on index conflicts.
module cl2_pl_exu_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NUM    = 32,
  parameter int IDXW   = $clog2(NUM),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NRD*IDXW-1:0]   rd_idx_i,
  output logic [NRD*XLEN-1:0]   rd_dat_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*IDXW-1:0]   wr_idx_i,
  input  logic [NWR*XLEN-1:0]   wr_dat_i,
  input  logic                  sb_set_i,
  input  logic [IDXW-1:0]       sb_idx_i,
  output logic [NUM-1:0]        busy_vec_o
);

  logic [XLEN-1:0] regs_q [NUM];
  logic [NUM-1:0]  busy_q;
  logic [NUM-1:0]  wr_hit;
  logic [XLEN-1:0] wr_val [NUM];
  logic [NUM-1:0]  sb_hit;

  // Per-register write decode; later ports overwrite earlier ones so the highest port wins.
  // Entry 0 never decodes a hit, which keeps it zero and out of the bypass path.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      wr_hit[i] = 1'b0;
      wr_val[i] = '0;
      sb_hit[i] = sb_set_i && (sb_idx_i == IDXW'(i)) && (i != 0);
      if (i != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_idx_i[p*IDXW +: IDXW] == IDXW'(i))) begin
            wr_hit[i] = 1'b1;
            wr_val[i] = wr_dat_i[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (wr_hit[i]) begin
          regs_q[i] <= wr_val[i];
        end
      end
    end
  end

  // A new issue supersedes the older pending writeback, so set dominates clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= sb_hit | (busy_q & ~wr_hit);
    end
  end

  always_comb begin
    rd_dat_o  = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (BYPASS && wr_hit[rd_idx_i[k*IDXW +: IDXW]]) begin
        rd_dat_o[k*XLEN +: XLEN] = wr_val[rd_idx_i[k*IDXW +: IDXW]];
        rd_busy_o[k]             = 1'b0;
      end else begin
        rd_dat_o[k*XLEN +: XLEN] = regs_q[rd_idx_i[k*IDXW +: IDXW]];
        rd_busy_o[k]             = busy_q[rd_idx_i[k*IDXW +: IDXW]];
      end
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_cl2_pl_exu_regfile_mp.sv
// tb/tb_cl2_pl_exu_regfile_mp.sv - bench for cl2_pl_exu_regfile_mp, bypass and non-bypass builds
module tb_cl2_pl_exu_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  rd_idx;
  logic [1:0]  wr_en;
  logic [9:0]  wr_idx;
  logic [63:0] wr_dat;
  logic        sb_set;
  logic [4:0]  sb_idx;

  logic [63:0] rd_dat_b, rd_dat_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  cl2_pl_exu_regfile_mp #(.XLEN(32), .NUM(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .rd_idx_i(rd_idx), .rd_dat_o(rd_dat_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_dat_i(wr_dat), .sb_set_i(sb_set), .sb_idx_i(sb_idx),
    .busy_vec_o(busy_vec_b)
  );

  cl2_pl_exu_regfile_mp #(.XLEN(32), .NUM(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) dut_n (
    .clk_i(clk), .rst_n_i(rst_n), .rd_idx_i(rd_idx), .rd_dat_o(rd_dat_n), .rd_busy_o(rd_busy_n),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_dat_i(wr_dat), .sb_set_i(sb_set), .sb_idx_i(sb_idx),
    .busy_vec_o(busy_vec_n)
  );

  task automatic idle();
    wr_en  = '0;
    wr_idx = '0;
    wr_dat = '0;
    sb_set = 1'b0;
    sb_idx = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rd_idx = {5'd2, 5'd1};
    #3 rst_n = 1'b0;
    #2;
    n_cmp++; if (rd_dat_b !== 64'h0) begin n_err++; $display("FAIL reset_rd_b: got %h want 0", rd_dat_b); end
    n_cmp++; if (rd_dat_n !== 64'h0) begin n_err++; $display("FAIL reset_rd_n: got %h want 0", rd_dat_n); end
    n_cmp++; if (busy_vec_b !== 32'h0 || rd_busy_b !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %h/%b want 0", busy_vec_b, rd_busy_b); end
    step(); step();
    rst_n = 1'b1;
    step();
    wr_en = 2'b01; wr_idx[4:0] = 5'd5; wr_dat[31:0] = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    step();
    idle();
    rd_idx = {5'd0, 5'd5};
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++; if (rd_dat_b[31:0] !== exp_v) begin n_err++; $display("FAIL x5_rd_b: got %h want %h", rd_dat_b[31:0], exp_v); end
    n_cmp++; if (rd_dat_n[31:0] !== exp_v) begin n_err++; $display("FAIL x5_rd_n: got %h want %h", rd_dat_n[31:0], exp_v); end
  endtask

  task automatic test_x0();
    step();
    wr_en = 2'b11; wr_idx = {5'd0, 5'd0}; wr_dat = {32'h12345678, 32'h12345678};
    sb_set = 1'b1; sb_idx = 5'd0;
    rd_idx = {5'd0, 5'd0};
    #1;
    n_cmp++; if (rd_dat_b !== 64'h0) begin n_err++; $display("FAIL x0_bypass: got %h want 0", rd_dat_b); end
    step();
    idle();
    #1;
    n_cmp++; if (rd_dat_b !== 64'h0 || rd_dat_n !== 64'h0) begin n_err++; $display("FAIL x0_read: got %h/%h want 0", rd_dat_b, rd_dat_n); end
    n_cmp++; if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin n_err++; $display("FAIL x0_busy: got %h/%h want 0", busy_vec_b, busy_vec_n); end
  endtask

  task automatic test_conflict();
    step();
    wr_en = 2'b11; wr_idx = {5'd7, 5'd7}; wr_dat = {32'h2222, 32'h1111};
    rd_idx = {5'd0, 5'd7};
    #1;
    n_cmp++; if (rd_dat_b[31:0] !== 32'h2222) begin n_err++; $display("FAIL conflict_bypass: got %h want 2222", rd_dat_b[31:0]); end
    n_cmp++; if (rd_dat_n[31:0] !== 32'h0) begin n_err++; $display("FAIL conflict_old: got %h want 0", rd_dat_n[31:0]); end
    step();
    idle();
    #1;
    n_cmp++; if (rd_dat_b[31:0] !== 32'h2222 || rd_dat_n[31:0] !== 32'h2222) begin n_err++; $display("FAIL conflict_stored: got %h/%h want 2222", rd_dat_b[31:0], rd_dat_n[31:0]); end
  endtask

  task automatic test_bypass();
    step();
    wr_en = 2'b10; wr_idx = {5'd3, 5'd0}; wr_dat = {32'hA5A5, 32'h0};
    rd_idx = {5'd3, 5'd0};
    #1;
    n_cmp++; if (rd_dat_b[63:32] !== 32'hA5A5) begin n_err++; $display("FAIL bypass_same: got %h want a5a5", rd_dat_b[63:32]); end
    n_cmp++; if (rd_dat_n[63:32] !== 32'h0) begin n_err++; $display("FAIL nobypass_same: got %h want 0", rd_dat_n[63:32]); end
    step();
    idle();
    #1;
    n_cmp++; if (rd_dat_n[63:32] !== 32'hA5A5) begin n_err++; $display("FAIL nobypass_next: got %h want a5a5", rd_dat_n[63:32]); end
  endtask

  task automatic test_scoreboard();
    step();
    sb_set = 1'b1; sb_idx = 5'd10;
    rd_idx = {5'd0, 5'd10};
    #1;
    n_cmp++; if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b0) begin n_err++; $display("FAIL sb_set_same: got %b/%b want 0", rd_busy_b[0], rd_busy_n[0]); end
    step();
    idle();
    #1;
    n_cmp++; if (busy_vec_b[10] !== 1'b1 || busy_vec_n[10] !== 1'b1) begin n_err++; $display("FAIL sb_vec_set: got %b/%b want 1", busy_vec_b[10], busy_vec_n[10]); end
    n_cmp++; if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1) begin n_err++; $display("FAIL sb_rd_busy: got %b/%b want 1", rd_busy_b[0], rd_busy_n[0]); end
    step();
    wr_en = 2'b10; wr_idx = {5'd10, 5'd0}; wr_dat = {32'hCAFE, 32'h0};
    #1;
    n_cmp++; if (rd_busy_b[0] !== 1'b0) begin n_err++; $display("FAIL sb_fwd_busy: got %b want 0", rd_busy_b[0]); end
    n_cmp++; if (rd_busy_n[0] !== 1'b1) begin n_err++; $display("FAIL sb_nofwd_busy: got %b want 1", rd_busy_n[0]); end
    n_cmp++; if (rd_dat_b[31:0] !== 32'hCAFE) begin n_err++; $display("FAIL sb_fwd_dat: got %h want cafe", rd_dat_b[31:0]); end
    step();
    idle();
    #1;
    n_cmp++; if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin n_err++; $display("FAIL sb_clear: got %h/%h want 0", busy_vec_b, busy_vec_n); end
    n_cmp++; if (rd_dat_n[31:0] !== 32'hCAFE || rd_busy_n[0] !== 1'b0) begin n_err++; $display("FAIL sb_after: got %h/%b want cafe/0", rd_dat_n[31:0], rd_busy_n[0]); end
  endtask

  task automatic test_set_clear();
    step();
    sb_set = 1'b1; sb_idx = 5'd10;
    step();
    idle();
    sb_set = 1'b1; sb_idx = 5'd10;
    wr_en = 2'b01; wr_idx = {5'd0, 5'd10}; wr_dat = {32'h0, 32'hBEEF};
    rd_idx = {5'd5, 5'd10};
    #1;
    n_cmp++; if (rd_busy_b[0] !== 1'b0 || rd_busy_n[0] !== 1'b1) begin n_err++; $display("FAIL sc_same: got %b/%b want 0/1", rd_busy_b[0], rd_busy_n[0]); end
    step();
    idle();
    #1;
    n_cmp++; if (busy_vec_b[10] !== 1'b1 || busy_vec_n[10] !== 1'b1) begin n_err++; $display("FAIL sc_set_wins: got %b/%b want 1", busy_vec_b[10], busy_vec_n[10]); end
    n_cmp++; if (rd_dat_b[31:0] !== 32'hBEEF || rd_dat_n[31:0] !== 32'hBEEF) begin n_err++; $display("FAIL sc_data: got %h/%h want beef", rd_dat_b[31:0], rd_dat_n[31:0]); end
    n_cmp++; if (rd_dat_n[63:32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sc_x5: got %h want deadbeef", rd_dat_n[63:32]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin n_err++; $display("FAIL async_busy: got %h/%h want 0", busy_vec_b, busy_vec_n); end
    n_cmp++; if (rd_dat_b !== 64'h0 || rd_dat_n !== 64'h0) begin n_err++; $display("FAIL async_data: got %h/%h want 0", rd_dat_b, rd_dat_n); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int r;
    int prev;
    prev = 0;
    step();
    for (int c = 0; c < 8; c++) begin
      idle();
      r = 11 + c;
      d = $urandom;
      wr_en[c%2] = 1'b1;
      wr_idx[(c%2)*5 +: 5] = 5'(r);
      wr_dat[(c%2)*32 +: 32] = d;
      rd_idx = {5'(prev), 5'(r)};
      #1;
      n_cmp++; if (rd_dat_b[31:0] !== d) begin n_err++; $display("FAIL b2b_fwd[%0d]: got %h want %h", c, rd_dat_b[31:0], d); end
      if (c > 0) begin
        exp_v = exp_q.pop_front();
        n_cmp++; if (rd_dat_n[63:32] !== exp_v) begin n_err++; $display("FAIL b2b_prev[%0d]: got %h want %h", c, rd_dat_n[63:32], exp_v); end
      end
      exp_q.push_back(d);
      prev = r;
      step();
    end
    idle();
    rd_idx = {5'(prev), 5'd0};
    #1;
    n_cmp++;
    if (exp_q.size() != 1) begin
      n_err++; $display("FAIL b2b_queue: got %0d entries want 1", exp_q.size());
    end else begin
      exp_v = exp_q.pop_front();
      if (rd_dat_n[63:32] !== exp_v) begin n_err++; $display("FAIL b2b_last: got %h want %h", rd_dat_n[63:32], exp_v); end
    end
  endtask

  initial begin
    idle();
    rd_idx = '0;
    test_reset();
    test_x0();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_set_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
